// File: rtl/pipe_cla_addsub_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_cla_addsub_if
// Purpose  : Operand/result handshake bundle for the pipelined CLA add/sub.
// Revision : 1.0
// ============================================================================
interface pipe_cla_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface
`default_nettype wire

// File: rtl/pipe_cla_addsub.sv
`default_nettype none
// ============================================================================
// Module   : pipe_cla_addsub
// Purpose  : Pipelined carry-lookahead adder/subtractor, one BLOCK group/stage.
// Revision : 1.0
// ============================================================================
module pipe_cla_addsub #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    pipe_cla_addsub_if.slave    bus_io
);
    localparam int STAGES = WIDTH / BLOCK;

    if (((WIDTH % BLOCK) != 0) || (WIDTH < BLOCK)) begin : g_param_check
        $error("pipe_cla_addsub: WIDTH must be a non-zero multiple of BLOCK");
    end

    // Flat sum-of-products lookahead: every carry is formed directly from
    // g/p and the group carry-in. Returns {carry into MSB, carry out, sum}.
    function automatic logic [BLOCK+1:0] cla_group(
        input logic [BLOCK-1:0] ga,
        input logic [BLOCK-1:0] gb,
        input logic             c0
    );
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] g;
        logic [BLOCK:0]   c;
        logic             t;
        p = ga ^ gb;
        g = ga & gb;
        c = '0;
        t = 1'b0;
        for (int i = 0; i <= BLOCK; i++) begin
            c[i] = c0;
            for (int j = 0; j < i; j++) c[i] = c[i] & p[j];
            for (int j = 0; j < i; j++) begin
                t = g[j];
                for (int k = j + 1; k < i; k++) t = t & p[k];
                c[i] = c[i] | t;
            end
        end
        return {c[BLOCK-1], c[BLOCK], p ^ c[BLOCK-1:0]};
    endfunction

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;
    logic              w_stall;

    assign w_stall         = v_q[STAGES-1] & ~bus_io.out_ready;
    assign bus_io.in_ready = ~w_stall;

    always_comb begin : comb_stages
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_s;
        logic             src_c;
        logic [BLOCK+1:0] grp;

        v_d = '0;
        c_d = '0;
        a_d = '{default: '0};
        b_d = '{default: '0};
        s_d = '{default: '0};

        // Stage 1 conditions the operands and resolves group 0 before its register.
        src_a = bus_io.a;
        src_b = bus_io.sub ? ~bus_io.b : bus_io.b;
        src_s = '0;
        src_c = bus_io.cin ^ bus_io.sub;
        grp   = cla_group(src_a[BLOCK-1:0], src_b[BLOCK-1:0], src_c);
        src_s[BLOCK-1:0] = grp[BLOCK-1:0];
        a_d[0] = src_a;
        b_d[0] = src_b;
        s_d[0] = src_s;
        c_d[0] = grp[BLOCK];
        v_d[0] = bus_io.in_valid & ~w_stall;

        for (int l = 1; l < STAGES; l++) begin
            src_a = a_q[l-1];
            src_b = b_q[l-1];
            src_s = s_q[l-1];
            src_c = c_q[l-1];
            grp   = cla_group(src_a[l*BLOCK +: BLOCK], src_b[l*BLOCK +: BLOCK], src_c);
            src_s[l*BLOCK +: BLOCK] = grp[BLOCK-1:0];
            a_d[l] = src_a;
            b_d[l] = src_b;
            s_d[l] = src_s;
            c_d[l] = grp[BLOCK];
            v_d[l] = v_q[l-1];
        end

        // grp now holds the most significant group, so flags ride with the final sum.
        ovf_d  = grp[BLOCK+1] ^ grp[BLOCK];
        zero_d = (s_d[STAGES-1] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            c_q    <= '0;
            a_q    <= '{default: '0};
            b_q    <= '{default: '0};
            s_q    <= '{default: '0};
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (!w_stall) begin
            v_q    <= v_d;
            c_q    <= c_d;
            a_q    <= a_d;
            b_q    <= b_d;
            s_q    <= s_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign bus_io.out_valid = v_q[STAGES-1];
    assign bus_io.sum       = s_q[STAGES-1];
    assign bus_io.cout      = c_q[STAGES-1];
    assign bus_io.ovf       = ovf_q;
    assign bus_io.zero      = zero_q;
endmodule
`default_nettype wire
